serial_adder_sub: RTL

- Parametrised, bit-serial add/subtract unit. One full-adder cell is reused over WIDTH cycles, LSB first.
- Successor to the single-bit half-adder cell. Adds: operand width, carry-in, subtract mode, overflow flag, valid/ready handshakes.
- Sits between a register-file style producer and a result consumer where area matters more than latency.

---
 rtl/arith_pkg.sv | 21 ++
 rtl/full_adder_cell.sv | 24 ++
 rtl/serial_adder_sub.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared types and encodings for the bit-serial arithmetic blocks.
package arith_pkg;

    // Sequencer states of the serial add/subtract unit.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Encoding of the sub input.
    localparam logic SUB_MODE_ADD = 1'b0;
    localparam logic SUB_MODE_SUB = 1'b1;

    // Operand B as seen by the adder: inverted in subtract mode so that
    // a - b - borrow becomes a + ~b + ~borrow.
    function automatic logic cond_invert(input logic bit_in, input logic sub_mode);
        return (sub_mode == SUB_MODE_SUB) ? ~bit_in : bit_in;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder built from two half-adder stages and an OR.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ha1_sum;
    logic ha1_carry;
    logic ha2_carry;

    // First half adder on the operand bits, second half adder folds in the
    // carry; either stage producing a carry yields the cell carry.
    always_comb begin
        ha1_sum   = a ^ b;
        ha1_carry = a & b;
        sum       = ha1_sum ^ cin;
        ha2_carry = ha1_sum & cin;
        cout      = ha1_carry | ha2_carry;
    end

endmodule

// File: rtl/serial_adder_sub.sv
// Bit-serial add/subtract unit: one full-adder cell reused over WIDTH
// cycles, LSB first, with valid/ready handshakes on both sides.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// RUN   | one operand bit pair per cycle through the full-adder cell
// DONE  | result presented with out_valid, held until out_ready
module serial_adder_sub
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic             c_msb_in;
    logic [CNT_W-1:0] idx;

    logic accept;
    logic last_bit;
    logic fa_sum;
    logic fa_cout;

    full_adder_cell u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake/result outputs; result ports read
    // zero outside DONE so partial sums in RUN never leak out.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        sum        = '0;
        carry_out  = 1'b0;
        overflow   = 1'b0;
        accept     = 1'b0;
        last_bit   = (idx == CNT_W'(WIDTH - 1));
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                sum       = res;
                carry_out = carry;
                overflow  = c_msb_in ^ carry;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // New sum bit enters at the MSB while the result shifts right, so after
    // WIDTH shifts bit 0 of the operands has landed in bit 0 of the result.
    always_comb begin
        res_next            = res >> 1;
        res_next[WIDTH-1]   = fa_sum;
    end

    // Operand capture and per-bit datapath update.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            res      <= '0;
            carry    <= 1'b0;
            c_msb_in <= 1'b0;
            idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a     <= a;
                        op_b     <= (sub == SUB_MODE_SUB) ? ~b : b;
                        carry    <= cond_invert(cin, sub);
                        c_msb_in <= 1'b0;
                        idx      <= '0;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    res   <= res_next;
                    carry <= fa_cout;
                    idx   <= idx + CNT_W'(1);
                    if (last_bit) begin
                        c_msb_in <= carry;
                    end
                end
                default: begin
                    op_a <= op_a;
                end
            endcase
        end
    end

endmodule
